// File: rtl/key_evt_pkg.sv
// Shared encodings for the key event classifier: FSM states, key levels
// and the bundle of single-cycle event pulses.
package key_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    typedef struct packed {
        logic short_press;
        logic double_click;
        logic long_press;
        logic repeat_pulse;
    } pulse_t;

endpackage : key_evt_pkg

// File: rtl/key_event_classifier.sv
// Classifies debounced key activity into short press, double click and long
// press, with auto-repeat while a long press is held. All outputs registered.
module key_event_classifier
    import key_evt_pkg::*;
#(
    parameter int unsigned LONG_CNT   = 50_000_000,
    parameter int unsigned DBL_CNT    = 15_000_000,
    parameter int unsigned REPEAT_CNT = 10_000_000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_flag,
    input  logic key_value,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_TC    = CNT_W'(DBL_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    pulse_t           pulse_q, pulse_d;
    logic             busy_q,  busy_d;
    logic             timer_reload;
    logic             press_ev, release_ev;

    // key_value is meaningless between strobes, so it is only looked at with key_flag.
    assign press_ev   = key_flag && (key_value == KEY_PRESSED);
    assign release_ev = key_flag && (key_value == KEY_RELEASED);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pulse_d      = '0;
        timer_reload = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (press_ev) begin
                    state_d = ST_PRESS1;
                end
            end
            ST_PRESS1: begin
                if (release_ev) begin
                    state_d = ST_WAIT2;
                end else if (timer_q == LONG_TC) begin
                    state_d            = ST_HOLD;
                    pulse_d.long_press = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (press_ev) begin
                    state_d = ST_PRESS2;
                end else if (timer_q == DBL_TC) begin
                    state_d             = ST_IDLE;
                    pulse_d.short_press = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (release_ev) begin
                    state_d              = ST_IDLE;
                    pulse_d.double_click = 1'b1;
                end
            end
            ST_HOLD: begin
                if (release_ev) begin
                    state_d = ST_IDLE;
                end else if (timer_q == REPEAT_TC) begin
                    pulse_d.repeat_pulse = 1'b1;
                    timer_reload         = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timer is parked at zero in IDLE so it can never run into a wrap.
        if (timer_reload || (state_d != state_q) || (state_d == ST_IDLE)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + CNT_W'(1);
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // update together from the values present before the edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pulse_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign short_press  = pulse_q.short_press;
    assign double_click = pulse_q.double_click;
    assign long_press   = pulse_q.long_press;
    assign repeat_pulse = pulse_q.repeat_pulse;
    assign busy         = busy_q;

endmodule : key_event_classifier

// File: tb/tb_key_event_classifier.sv
// Bench for key_event_classifier: directed press sequences checked every cycle
// against a duration-based model, plus hand-computed pulse timings.
module tb_key_event_classifier;

    localparam int LONG_CNT   = 20;
    localparam int DBL_CNT    = 10;
    localparam int REPEAT_CNT = 5;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_flag = 1'b0;
    logic key_value = 1'b1;
    logic short_press, double_click, long_press, repeat_pulse, busy;

    key_event_classifier #(
        .LONG_CNT  (LONG_CNT),
        .DBL_CNT   (DBL_CNT),
        .REPEAT_CNT(REPEAT_CNT),
        .CNT_W     (8)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_flag    (key_flag),
        .key_value   (key_value),
        .short_press (short_press),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: tracks which phase of a press gesture the key is in and the cycle
    // that phase began; pulses fire when a phase has lasted its full duration.
    typedef enum {M_IDLE, M_DOWN1, M_GAP, M_DOWN2, M_HELD} mphase_e;
    mphase_e m_phase = M_IDLE;
    int      m_start = 0;
    int      now     = 0;
    logic    exp_sp = 1'b0, exp_dc = 1'b0, exp_lp = 1'b0, exp_rp = 1'b0, exp_busy = 1'b0;

    task automatic enter(input mphase_e p);
        m_phase = p;
        m_start = now + 1;
    endtask

    task automatic model_step();
        int  lasted;
        bit  pressed, released;
        if (sys_rst) begin
            m_phase = M_IDLE;
            {exp_sp, exp_dc, exp_lp, exp_rp, exp_busy} = '0;
            return;
        end
        lasted   = now - m_start + 1;  // cycles spent in phase including this one
        pressed  = key_flag && (key_value == 1'b0);
        released = key_flag && (key_value == 1'b1);
        {exp_sp, exp_dc, exp_lp, exp_rp} = '0;
        case (m_phase)
            M_IDLE:  if (pressed) enter(M_DOWN1);
            M_DOWN1: if (released) enter(M_GAP);
                     else if (lasted == LONG_CNT) begin exp_lp = 1'b1; enter(M_HELD); end
            M_GAP:   if (pressed) enter(M_DOWN2);
                     else if (lasted == DBL_CNT) begin exp_sp = 1'b1; enter(M_IDLE); end
            M_DOWN2: if (released) begin exp_dc = 1'b1; enter(M_IDLE); end
            M_HELD:  if (released) enter(M_IDLE);
                     else if (lasted == REPEAT_CNT) begin exp_rp = 1'b1; m_start = now + 1; end
            default: enter(M_IDLE);
        endcase
        exp_busy = (m_phase != M_IDLE);
        now++;
    endtask

    always begin
        @(posedge sys_clk or posedge sys_rst);
        model_step();
    end

    // Single compare process: every cycle out of reset, all outputs vs model.
    always begin
        @(posedge sys_clk);
        #1;
        if (!sys_rst) begin
            check("short_press",  int'(short_press),  int'(exp_sp));
            check("double_click", int'(double_click), int'(exp_dc));
            check("long_press",   int'(long_press),   int'(exp_lp));
            check("repeat_pulse", int'(repeat_pulse), int'(exp_rp));
            check("busy",         int'(busy),         int'(exp_busy));
        end
    end

    // Per-scenario observation log (cycle index relative to scenario start).
    int   ev_t[$];
    logic ev_v[$];
    int   sp_n, dc_n, lp_n, rp_n;
    int   sp_first, dc_first, lp_first, rp_first;
    logic busy_log[64];

    task automatic log_outputs(input int t);
        if (short_press)  begin sp_n++; if (sp_first < 0) sp_first = t; end
        if (double_click) begin dc_n++; if (dc_first < 0) dc_first = t; end
        if (long_press)   begin lp_n++; if (lp_first < 0) lp_first = t; end
        if (repeat_pulse) begin rp_n++; if (rp_first < 0) rp_first = t; end
        busy_log[t] = busy;
    endtask

    // Drives the scheduled flags in cycles 0..len-1; key_value is randomised
    // whenever no flag is present.
    task automatic run(input int len);
        sp_n = 0; dc_n = 0; lp_n = 0; rp_n = 0;
        sp_first = -1; dc_first = -1; lp_first = -1; rp_first = -1;
        for (int t = 0; t < len; t++) begin
            @(negedge sys_clk);
            log_outputs(t);
            key_flag  = 1'b0;
            key_value = 1'($urandom_range(0, 1));
            for (int i = 0; i < ev_t.size(); i++) begin
                if (ev_t[i] == t) begin
                    key_flag  = 1'b1;
                    key_value = ev_v[i];
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("reset_outputs", int'({short_press, double_click, long_press, repeat_pulse, busy}), 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Single press/release, gap expires.
        ev_t = '{0, 6}; ev_v = '{1'b0, 1'b1};
        run(30);
        check("s1_short_cnt", sp_n, 1);
        check("s1_short_at",  sp_first, 17);
        check("s1_other_cnt", dc_n + lp_n + rp_n, 0);

        // Double click.
        ev_t = '{0, 4, 9, 13}; ev_v = '{1'b0, 1'b1, 1'b0, 1'b1};
        run(30);
        check("s2_dbl_at",     dc_first, 14);
        check("s2_short_cnt",  sp_n, 0);

        // Long press with auto-repeat, then release.
        ev_t = '{0, 32}; ev_v = '{1'b0, 1'b1};
        run(40);
        check("s3_long_at",    lp_first, 21);
        check("s3_rep_at",     rp_first, 26);
        check("s3_rep_cnt",    rp_n, 2);
        check("s3_busy_32",    int'(busy_log[32]), 1);
        check("s3_busy_33",    int'(busy_log[33]), 0);

        // Release on the long-press terminal cycle: release wins.
        ev_t = '{0, 20}; ev_v = '{1'b0, 1'b1};
        run(40);
        check("s4_long_cnt",   lp_n, 0);
        check("s4_short_at",   sp_first, 31);

        // Second press on the double-click terminal cycle: press wins.
        ev_t = '{0, 4, 14, 16}; ev_v = '{1'b0, 1'b1, 1'b0, 1'b1};
        run(30);
        check("s4b_short_cnt", sp_n, 0);
        check("s4b_dbl_at",    dc_first, 17);

        // Redundant press flags; release on the repeat terminal cycle.
        ev_t = '{0, 3, 8, 25}; ev_v = '{1'b0, 1'b0, 1'b0, 1'b1};
        run(40);
        check("s6_long_at",    lp_first, 21);
        check("s6_rep_cnt",    rp_n, 0);
        check("s6_short_cnt",  sp_n, 0);

        // Asynchronous reset while a repeat pulse is on the outputs.
        ev_t = '{0}; ev_v = '{1'b0};
        run(27);
        check("s5_rep_before", rp_first, 26);
        #2 sys_rst = 1'b1;
        #1;
        check("s5_rst_repeat", int'(repeat_pulse), 0);
        check("s5_rst_busy",   int'(busy), 0);
        check("s5_rst_all",    int'({short_press, double_click, long_press}), 0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;

        // After reset: stray release ignored, next press times from scratch.
        ev_t = '{0, 2, 30}; ev_v = '{1'b1, 1'b0, 1'b1};
        run(45);
        check("s5_long_at",    lp_first, 23);
        check("s5_rep_at",     rp_first, 28);
        check("s5_rep_cnt",    rp_n, 1);
        check("s5_short_cnt",  sp_n + dc_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_key_event_classifier
